// File: rtl/aes32_state_loader.sv
// Collects four 32-bit columns into one 128-bit AES state, optionally applying
// the initial AddRoundKey on capture, and holds it until the round stage takes it.
module aes32_state_loader #(
    parameter int ADD_KEY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] key_word,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout_0,
    output logic [31:0] dout_1,
    output logic [31:0] dout_2,
    output logic [31:0] dout_3,
    output logic [1:0]  word_cnt
);

    // Handshakes: a word moves when in_valid && in_ready; a state moves when
    // out_valid && out_ready. Neither side may depend on the other's valid.
    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  r_word_cnt;
    logic [31:0] r_col [4];

    logic        w_in_fill;
    logic        w_in_full;
    logic        w_handshake;
    logic        w_last_word;
    logic [31:0] w_cap_word;

    assign w_in_fill = (r_state == S_FILL);
    assign w_in_full = (r_state == S_FULL);

    // In FULL, a new word is only accepted when the held state leaves in the same cycle.
    assign in_ready = !rst && !flush && (w_in_fill || (w_in_full && out_ready));

    assign w_handshake = in_valid && in_ready;
    assign w_last_word = w_in_fill && (r_word_cnt == 2'd3);
    assign w_cap_word  = (ADD_KEY != 0) ? (in_data ^ key_word) : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FILL;
            r_word_cnt <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_col[i] <= 32'h0;
            end
        end else begin
            if (w_handshake) begin
                r_col[r_word_cnt] <= w_cap_word;
                r_word_cnt        <= r_word_cnt + 2'd1;
            end else if (flush && w_in_fill) begin
                r_word_cnt <= 2'd0;
            end

            case (r_state)
                S_FILL: begin
                    if (w_handshake && w_last_word) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        r_state <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign out_valid = w_in_full;
    assign word_cnt  = r_word_cnt;
    assign dout_0    = r_col[0];
    assign dout_1    = r_col[1];
    assign dout_2    = r_col[2];
    assign dout_3    = r_col[3];

endmodule

// File: tb/tb_aes32_state_loader.sv
// Bench for aes32_state_loader: two instances (ADD_KEY=1 and ADD_KEY=0) share
// stimulus and are checked against a word-grouping reference model.
module tb_aes32_state_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] key_word;
  logic        flush;
  logic        out_ready;

  logic        rdy_k, ov_k, rdy_p, ov_p;
  logic [31:0] d0_k, d1_k, d2_k, d3_k, d0_p, d1_p, d2_p, d3_p;
  logic [1:0]  wc_k, wc_p;

  aes32_state_loader #(.ADD_KEY(1)) dut_k (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_k),
    .in_data(in_data), .key_word(key_word), .flush(flush),
    .out_valid(ov_k), .out_ready(out_ready),
    .dout_0(d0_k), .dout_1(d1_k), .dout_2(d2_k), .dout_3(d3_k),
    .word_cnt(wc_k)
  );

  aes32_state_loader #(.ADD_KEY(0)) dut_p (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_p),
    .in_data(in_data), .key_word(key_word), .flush(flush),
    .out_valid(ov_p), .out_ready(out_ready),
    .dout_0(d0_p), .dout_1(d1_p), .dout_2(d2_p), .dout_3(d3_p),
    .word_cnt(wc_p)
  );

  // ---------------- reference model ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic        m_full;
  int          m_cnt;
  logic [31:0] mcol_k [4];
  logic [31:0] mcol_p [4];
  logic [127:0] exp_qk[$];
  logic [127:0] exp_qp[$];
  int          pulses;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      mcol_k[i] = 32'h0;
      mcol_p[i] = 32'h0;
    end
    exp_qk.delete();
    exp_qp.delete();
  endtask

  // Compare every observable output against the model, sampled between edges.
  task automatic check_all();
    logic exp_rdy;
    exp_rdy = !rst && !flush && (!m_full || out_ready);
    chk("in_ready_k", 128'(rdy_k), 128'(exp_rdy));
    chk("in_ready_p", 128'(rdy_p), 128'(exp_rdy));
    chk("out_valid_k", 128'(ov_k), 128'(m_full));
    chk("out_valid_p", 128'(ov_p), 128'(m_full));
    chk("word_cnt_k", 128'(wc_k), 128'(m_cnt));
    chk("word_cnt_p", 128'(wc_p), 128'(m_cnt));
    chk("dout_k", {d0_k, d1_k, d2_k, d3_k}, {mcol_k[0], mcol_k[1], mcol_k[2], mcol_k[3]});
    chk("dout_p", {d0_p, d1_p, d2_p, d3_p}, {mcol_p[0], mcol_p[1], mcol_p[2], mcol_p[3]});
    if (m_full && out_ready && !rst) begin
      if (exp_qk.size() == 0 || exp_qp.size() == 0) begin
        chk("scoreboard_empty", 128'(exp_qk.size()), 128'(1));
      end else begin
        chk("block_k", {d0_k, d1_k, d2_k, d3_k}, exp_qk[0]);
        chk("block_p", {d0_p, d1_p, d2_p, d3_p}, exp_qp[0]);
      end
    end
  endtask

  // Apply the spec's rules for one clock edge using the inputs currently held.
  task automatic model_edge();
    logic exp_rdy, hs, consume;
    exp_rdy = !rst && !flush && (!m_full || out_ready);
    hs      = in_valid && exp_rdy;
    consume = m_full && out_ready;
    if (consume) begin
      if (exp_qk.size() > 0) void'(exp_qk.pop_front());
      if (exp_qp.size() > 0) void'(exp_qp.pop_front());
      m_full = 1'b0;
    end else if (flush && !m_full) begin
      m_cnt = 0;
    end
    if (hs) begin
      mcol_k[m_cnt] = in_data ^ key_word;
      mcol_p[m_cnt] = in_data;
      m_cnt++;
      if (m_cnt == 4) begin
        exp_qk.push_back({mcol_k[0], mcol_k[1], mcol_k[2], mcol_k[3]});
        exp_qp.push_back({mcol_p[0], mcol_p[1], mcol_p[2], mcol_p[3]});
        m_full = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a negedge; leaves the bench just after the next negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic [31:0] k,
                      input logic f, input logic ordy);
    in_valid  = v;
    in_data   = d;
    key_word  = k;
    flush     = f;
    out_ready = ordy;
    #1;
    check_all();
    if (ov_k) pulses++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 1'b0, ordy);
  endtask

  logic [31:0] vec_d [4];
  logic [31:0] vec_k [4];

  initial begin
    vec_d[0] = 32'h00112233; vec_d[1] = 32'h44556677;
    vec_d[2] = 32'h8899aabb; vec_d[3] = 32'hccddeeff;
    vec_k[0] = 32'h00010203; vec_k[1] = 32'h04050607;
    vec_k[2] = 32'h08090a0b; vec_k[3] = 32'h0c0d0e0f;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; key_word = '0; flush = 1'b0; out_ready = 1'b0;
    pulses = 0;
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    rst = 1'b0;
    idle(1'b0);

    // Known-answer block; state then held under backpressure for 5 cycles.
    for (int i = 0; i < 4; i++) step(1'b1, vec_d[i], vec_k[i], 1'b0, 1'b0);
    chk("kat_addkey", {d0_k, d1_k, d2_k, d3_k},
        128'h00102030_40506070_8090a0b0_c0d0e0f0);
    chk("kat_plain", {d0_p, d1_p, d2_p, d3_p},
        128'h00112233_44556677_8899aabb_ccddeeff);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hdeadbeef, 32'h0, 1'b0, 1'b0);
    chk("kat_hold_valid", 128'(ov_k), 128'(1));
    idle(1'b1);

    // Back-to-back traffic over three blocks.
    pulses = 0;
    for (int i = 0; i < 12; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    idle(1'b1);
    chk("b2b_pulses", 128'(pulses), 128'(3));
    chk("b2b_drained", 128'(exp_qk.size()), 128'(0));

    // Partial block flushed, then a fresh block.
    step(1'b1, 32'h11111111, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h22222222, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h33333333, 32'h0, 1'b1, 1'b0);
    chk("flush_cnt", 128'(wc_k), 128'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 32'ha0000000 + 32'(i), 32'h0, 1'b0, 1'b0);
    chk("flush_block", {d0_p, d1_p, d2_p, d3_p},
        128'ha0000000_a0000001_a0000002_a0000003);
    idle(1'b1);

    // Asynchronous reset while a full state is held.
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    chk("pre_rst_full", 128'(ov_k), 128'(1));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_dout", {d0_k, d1_k, d2_k, d3_k}, 128'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0);

    // Random traffic with stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4 && m_full; i++) idle(1'b1);
    chk("final_drain_k", 128'(exp_qk.size()), 128'(0));
    chk("final_drain_p", 128'(exp_qp.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes32_state_loader.md
AES32_STATE_LOADER -- requirements
Module: aes32_state_loader

Interface
REQ-001 Parameter: ADD_KEY, default 1, meaning 1 = XOR each input word with key_word on capture (initial AddRoundKey), 0 = capture in_data unmodified.
REQ-002 Port: clk  input  1  single clock for the block; all registers update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  producer has a valid word on in_data and key_word.
REQ-005 Port: in_ready  output  1  block can accept a word this cycle.
REQ-006 Port: in_data  input  32  plaintext word; bits [31:24] are row 0 and bits [7:0] are row 3 of the current column.
REQ-007 Port: key_word  input  32  round-0 key word aligned with in_data; same byte ordering as in_data.
REQ-008 Port: flush  input  1  abort the partially filled block.
REQ-009 Port: out_valid  output  1  a complete 128-bit state is presented on dout_0..dout_3.
REQ-010 Port: out_ready  input  1  the downstream ShiftRows/round stage consumes the state this cycle.
REQ-011 Port: dout_0, dout_1, dout_2, dout_3  output  32 each  state columns 0..3, in the column order expected by the downstream row-shift stage.
REQ-012 Port: word_cnt  output  2  index of the next column to be filled.

Function
REQ-013 The block SHALL use a two-state FSM: FILL (collecting words) and FULL (holding a complete state).
REQ-014 A handshake SHALL occur when in_valid=1 and in_ready=1 in the same cycle; no word is captured otherwise.
REQ-015 On a handshake, column register [word_cnt] SHALL load in_data^key_word if ADD_KEY=1, or in_data if ADD_KEY=0, and word_cnt SHALL increment modulo 4.
REQ-016 Column order SHALL be fixed: the first word captured after entering FILL goes to dout_0, then dout_1, dout_2, dout_3.
REQ-017 A handshake while word_cnt=3 SHALL move the FSM to FULL and wrap word_cnt to 0, with out_valid=1 on the following cycle.
REQ-018 Capture latency: a word captured at edge N SHALL be visible on its dout at edge N.
REQ-019 In FULL, out_valid SHALL be 1 and dout_0..3 SHALL hold stable until the state is consumed.
REQ-020 In FULL with out_ready=1, the FSM SHALL return to FILL at the next edge and out_valid SHALL drop to 0.
REQ-021 in_ready SHALL equal (state==FILL && !flush) || (state==FULL && out_ready && !flush), which gives back-to-back throughput of 4 words per block.
REQ-022 A handshake in the same cycle as a FULL consume SHALL load column 0 and set word_cnt=1.
REQ-023 In FILL, dout_k SHALL equal column register k at all times; columns not yet rewritten in the current block hold stale data and SHALL be ignored by the consumer while out_valid=0.
REQ-024 flush=1 in FILL SHALL reset word_cnt to 0 and capture no word; column registers are not cleared.
REQ-025 flush=1 in FULL SHALL be ignored, so a complete state is never dropped; in_ready is 0 while flush=1.
REQ-026 out_ready while in FILL SHALL have no effect.
REQ-027 The block SHALL contain no combinational path from in_data or key_word to out_valid.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force FSM=FILL, word_cnt=0, out_valid=0 and dout_0..3=32'h0, with in_ready=0.
REQ-029 Reset asserted mid-block or in FULL SHALL discard all partial and complete data.
REQ-030 After rst deasserts, in_ready SHALL be 1 in the first cycle unless flush=1.

Verification
REQ-031 ADD_KEY=1, words 00112233, 44556677, 8899aabb, ccddeeff with keys 00010203, 04050607, 08090a0b, 0c0d0e0f -> out_valid=1 with dout_0..3 = 00102030, 40506070, 8090a0b0, c0d0e0f0.
REQ-032 Same words with ADD_KEY=0 and out_ready held 0 for 5 cycles -> dout stable at 00112233, 44556677, 8899aabb, ccddeeff; in_ready=0 throughout; out_valid=1 throughout.
REQ-033 Continuous in_valid=1 and out_ready=1 over 3 blocks -> one out_valid pulse every 4 cycles, with no word lost or duplicated.
REQ-034 Two words captured, then flush=1 for one cycle, then 4 new words -> word_cnt=0 after flush, and the output block contains only the 4 new words.
REQ-035 rst asserted asynchronously between clock edges while in FULL -> out_valid and dout cleared to 0 immediately, and word_cnt=0.
REQ-036 in_valid toggling randomly with out_ready randomly stalled -> the sequence of output blocks equals the sequence of input words grouped in fours, with the XOR applied.
